// File: rtl/hack_soc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hack_soc_pkg                                                         |
// | Shared byte width and ROM feeder state encoding.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package hack_soc_pkg;

    localparam int BYTE_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LRESET   = 3'd1,
        ST_BYTE_HI  = 3'd2,
        ST_BYTE_LO  = 3'd3,
        ST_LOAD     = 3'd4,
        ST_WAIT_ACK = 3'd5,
        ST_DONE     = 3'd6
    } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/byte_to_word_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | byte_to_word_packer                                                  |
// | Two-byte big-endian word assembler; the word updates only once both  |
// | bytes are in, so an abandoned high byte never reaches the output.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module byte_to_word_packer
    import hack_soc_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  take,
    input  logic                  low_phase,
    input  logic [BYTE_WIDTH-1:0] byte_data,
    output logic [DATA_WIDTH-1:0] word
);

    logic [BYTE_WIDTH-1:0] r_hi;
    logic [DATA_WIDTH-1:0] r_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi   <= '0;
            r_word <= '0;
        end else if (take) begin
            if (low_phase) begin
                r_word <= {r_hi, byte_data};
            end else begin
                r_hi <= byte_data;
            end
        end
    end

    assign word = r_word;

endmodule
`default_nettype wire

// File: rtl/serial_rom_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_rom_feeder                                                    |
// | Packs a byte stream into 16-bit words and hands them one at a time   |
// | to a ROM stream loader, counting acknowledged words.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module serial_rom_feeder
    import hack_soc_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int COUNT_WIDTH  = 16,
    parameter int RESET_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic [COUNT_WIDTH-1:0] word_count,
    input  logic                   byte_valid,
    input  logic [BYTE_WIDTH-1:0]  byte_data,
    output logic                   byte_ready,
    output logic                   rom_loader_reset,
    output logic                   rom_loader_load,
    output logic [DATA_WIDTH-1:0]  rom_loader_data,
    input  logic                   rom_loader_load_received,
    input  logic                   rom_loader_ack,
    output logic                   busy,
    output logic                   done_loading,
    output logic [COUNT_WIDTH-1:0] words_loaded
);

    localparam int                c_RST_W    = $clog2(RESET_CYCLES + 1);
    localparam logic [c_RST_W-1:0] c_RST_LAST = c_RST_W'(RESET_CYCLES - 1);

    feeder_state_t          r_state;
    feeder_state_t          w_next_state;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] r_words;
    logic [COUNT_WIDTH-1:0] w_words_inc;
    logic [c_RST_W-1:0]     r_rst_cnt;
    logic                   w_take;
    logic                   w_count_word;
    logic                   r_byte_ready;
    logic                   r_loader_reset;
    logic                   r_loader_load;
    logic                   r_busy;
    logic                   r_done;

    assign w_take      = byte_valid && r_byte_ready && run;
    assign w_words_inc = (r_words == '1) ? r_words : r_words + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Dropping run aborts every busy state ahead of any other transition.
    always_comb begin
        w_next_state = r_state;
        w_count_word = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) w_next_state = ST_LRESET;
            end
            ST_LRESET: begin
                if (!run) begin
                    w_next_state = ST_IDLE;
                end else if (r_rst_cnt == c_RST_LAST) begin
                    w_next_state = (r_count == '0) ? ST_DONE : ST_BYTE_HI;
                end
            end
            ST_BYTE_HI: begin
                if (!run)        w_next_state = ST_IDLE;
                else if (w_take) w_next_state = ST_BYTE_LO;
            end
            ST_BYTE_LO: begin
                if (!run)        w_next_state = ST_IDLE;
                else if (w_take) w_next_state = ST_LOAD;
            end
            ST_LOAD: begin
                if (!run) begin
                    w_next_state = ST_IDLE;
                end else if (rom_loader_load_received) begin
                    if (rom_loader_ack) begin
                        w_count_word = 1'b1;
                        w_next_state = (w_words_inc == r_count) ? ST_DONE : ST_BYTE_HI;
                    end else begin
                        w_next_state = ST_WAIT_ACK;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (!run) begin
                    w_next_state = ST_IDLE;
                end else if (rom_loader_ack) begin
                    w_count_word = 1'b1;
                    w_next_state = (w_words_inc == r_count) ? ST_DONE : ST_BYTE_HI;
                end
            end
            ST_DONE: begin
                if (!run) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count        <= '0;
            r_words        <= '0;
            r_rst_cnt      <= '0;
            r_byte_ready   <= 1'b0;
            r_loader_reset <= 1'b0;
            r_loader_load  <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && run) begin
                r_count <= word_count;
                r_words <= '0;
            end else if (w_count_word) begin
                r_words <= w_words_inc;
            end

            if (r_state == ST_LRESET) begin
                r_rst_cnt <= r_rst_cnt + c_RST_W'(1);
            end else begin
                r_rst_cnt <= '0;
            end

            r_byte_ready   <= (w_next_state == ST_BYTE_HI) || (w_next_state == ST_BYTE_LO);
            r_loader_reset <= (w_next_state == ST_LRESET);
            r_loader_load  <= (w_next_state == ST_LOAD);
            r_busy         <= (w_next_state != ST_IDLE) && (w_next_state != ST_DONE);
            r_done         <= (w_next_state == ST_DONE);
        end
    end

    byte_to_word_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .take      (w_take),
        .low_phase (r_state == ST_BYTE_LO),
        .byte_data (byte_data),
        .word      (rom_loader_data)
    );

    assign byte_ready       = r_byte_ready;
    assign rom_loader_reset = r_loader_reset;
    assign rom_loader_load  = r_loader_load;
    assign busy             = r_busy;
    assign done_loading     = r_done;
    assign words_loaded     = r_words;

endmodule
`default_nettype wire
